// File: rtl/node_stack.sv
// LIFO stack node on the 4-port neighbour fabric: pushes whatever a neighbour sends,
// offers the top entry to all neighbours, one push and at most one pop per cycle.
module node_stack #(
  parameter int DEPTH = 15,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] in0,
  input  logic signed [10:0] in1,
  input  logic signed [10:0] in2,
  input  logic signed [10:0] in3,
  input  logic [3:0]         ready,
  input  logic [3:0]         done,
  output logic signed [10:0] outData,
  output logic [3:0]         send,
  output logic [3:0]         recv,
  output logic [CW-1:0]      count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [10:0] mem [DEPTH];

  logic [3:0]         elig;
  logic [1:0]         win;
  logic signed [10:0] win_data;
  logic               push;
  logic               pop;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic [CW-1:0]      count_nx;
  logic signed [10:0] out_nx;
  logic [3:0]         recv_nx;
  logic [3:0]         send_nx;

  always_comb begin
    elig     = ready & ~recv;
    win      = 2'd0;
    win_data = in0;
    if (elig[0]) begin
      win      = 2'd0;
      win_data = in0;
    end else if (elig[1]) begin
      win      = 2'd1;
      win_data = in1;
    end else if (elig[2]) begin
      win      = 2'd2;
      win_data = in2;
    end else if (elig[3]) begin
      win      = 2'd3;
      win_data = in3;
    end

    pop  = (|send) && (|done);
    push = (|elig) && ((count < CW'(DEPTH)) || pop);

    count_nx = count;
    wr_addr  = AW'(count);
    rd_addr  = AW'(count - CW'(2));
    out_nx   = outData;

    // Push with a simultaneous pop overwrites the old top in place.
    if (push && pop) begin
      wr_addr = AW'(count - CW'(1));
      out_nx  = win_data;
    end else if (push) begin
      count_nx = count + CW'(1);
      out_nx   = win_data;
    end else if (pop) begin
      count_nx = count - CW'(1);
      if (count > CW'(1))
        out_nx = mem[rd_addr];
    end

    recv_nx = push ? (4'b0001 << win) : 4'b0000;
    // A pop forces a silent cycle so a late done cannot take the same value twice;
    // the registered send itself serves as the gap flag.
    send_nx = ((count_nx != '0) && !pop) ? 4'b1111 : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      send    <= '0;
      recv    <= '0;
      outData <= '0;
    end else begin
      count   <= count_nx;
      send    <= send_nx;
      recv    <= recv_nx;
      outData <= out_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_addr] <= win_data;
  end

endmodule

// File: tb/tb_node_stack.sv
// Directed bench for node_stack: push/pop handshakes, priority, gap cycle, full and reset.
module tb_node_stack;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [10:0] din [4];
  logic [3:0]         ready;
  logic [3:0]         done;
  logic signed [10:0] outData;
  logic [3:0]         send;
  logic [3:0]         recv;
  logic [7:0]         count;

  int checks = 0;
  int passes = 0;

  node_stack #(.DEPTH(15), .CW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .in0     (din[0]),
    .in1     (din[1]),
    .in2     (din[2]),
    .in3     (din[3]),
    .ready   (ready),
    .done    (done),
    .outData (outData),
    .send    (send),
    .recv    (recv),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = '0; done = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input int p, input int v);
    din[p] = 11'(v);
    ready[p] = 1'b1;
    step();
    chk("push_recv", int'(recv), 1 << p);
    ready[p] = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = '0;
    ready = '0; done = '0; rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state and idle done pulses
    chk("rst_count", int'(count), 0);
    chk("rst_send", int'(send), 0);
    chk("rst_recv", int'(recv), 0);
    chk("rst_out", int'(outData), 0);
    done = 4'b1111;
    step();
    done = '0;
    chk("idle_done_count", int'(count), 0);
    chk("idle_done_send", int'(send), 0);

    // Single push from port 2, ready held through the recv cycle
    din[2] = 11'sd5; ready = 4'b0100;
    step();
    chk("p2_recv", int'(recv), 4'b0100);
    chk("p2_count", int'(count), 1);
    chk("p2_out", int'(outData), 5);
    chk("p2_send", int'(send), 4'b1111);
    step();
    chk("p2_recv_once", int'(recv), 0);
    chk("p2_no_second", int'(count), 1);
    ready = '0;
    step();

    // Priority: ports 1 and 3 simultaneously
    do_reset();
    din[1] = 11'sd7; din[3] = -11'sd3; ready = 4'b1010;
    step();
    chk("pri_recv1", int'(recv), 4'b0010);
    chk("pri_out1", int'($signed(outData)), 7);
    ready = 4'b1000;
    step();
    chk("pri_recv3", int'(recv), 4'b1000);
    ready = '0;
    step();
    chk("pri_out", int'($signed(outData)), -3);
    chk("pri_count", int'(count), 2);

    // Pop, gap cycle, multi-done pops once, done ignored during gap
    do_reset();
    push(0, 1); push(0, 2); push(0, 3);
    chk("pop_pre_count", int'(count), 3);
    chk("pop_pre_out", int'(outData), 3);
    done = 4'b0001;
    step();
    done = '0;
    chk("pop_count", int'(count), 2);
    chk("pop_gap_send", int'(send), 0);
    chk("pop_gap_out", int'(outData), 2);
    step();
    chk("pop_resend", int'(send), 4'b1111);
    chk("pop_out", int'(outData), 2);
    done = 4'b0101;
    step();
    chk("multi_done_count", int'(count), 1);
    chk("multi_done_out", int'(outData), 1);
    step();
    chk("gap_done_ignored", int'(count), 1);
    chk("gap_after_send", int'(send), 4'b1111);
    done = '0;
    step();

    // Full stack: blocked push, then push completes on the same cycle as a pop
    do_reset();
    for (int v = 0; v < 15; v++) push(v % 4, v);
    chk("full_count", int'(count), 15);
    chk("full_out", int'(outData), 14);
    din[0] = 11'sd99; ready = 4'b0001;
    step();
    step();
    chk("full_no_recv", int'(recv), 0);
    chk("full_hold_count", int'(count), 15);
    done = 4'b0001;
    step();
    done = '0; ready = '0;
    chk("full_swap_recv", int'(recv), 4'b0001);
    chk("full_swap_count", int'(count), 15);
    chk("full_swap_out", int'(outData), 99);
    chk("full_swap_gap", int'(send), 0);
    step();
    chk("full_swap_send", int'(send), 4'b1111);
    done = 4'b0001;
    step();
    done = '0;
    chk("full_under_count", int'(count), 14);
    chk("full_under_out", int'(outData), 13);

    // Mid-operation reset
    do_reset();
    push(0, 4); push(1, 5); push(2, 6); push(3, 7);
    chk("mid_count", int'(count), 4);
    din[1] = 11'sd9; ready = 4'b0010; rst = 1'b1;
    step();
    rst = 1'b0; ready = '0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_recv", int'(recv), 0);
    chk("mid_rst_send", int'(send), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/node_stack.md
# node_stack

Stack memory node for the TIS-style node array. It has no program. It sits on the same 4-port neighbour fabric as the T21 compute nodes and acts as a LIFO: values sent to it by any neighbour are pushed, and the top value is offered to every neighbour. It feeds and consumes the compute nodes directly, so its port protocol is the node-to-node protocol, mirrored.

## Interface
- DEPTH, 15: number of 11-bit entries; legal range 1..255.
- CW, 8: width of `count`; must hold DEPTH.
- clk  in  1  clock, shared with all nodes.
- rst  in  1  reset, synchronous, active-high.
- in0..in3  in  11 (signed)  data from neighbour 0..3 (neighbour's outData).
- ready  in  4  neighbour k is sending to this node (neighbour's send toward us).
- done  in  4  neighbour k consumed our offered value (neighbour's recv toward us).
- outData  out  11 (signed)  current top of stack, registered.
- send  out  4  offering outData to neighbour k, registered.
- recv  out  4  one-cycle strobe: value from neighbour k was pushed, registered.
- count  out  CW  current occupancy, registered.

## Operation
- Storage: DEPTH × 11-bit array, plus `count`. The top entry is mem[count-1]. Values are stored unmodified; there is no arithmetic on data.
- Push arbitration, each cycle:
  - Port k is eligible when ready[k] && !recv[k]. The recv mask blocks re-accepting a sender that is still holding ready while it sees its done.
  - The lowest eligible index wins, in priority order 0 > 1 > 2 > 3.
  - A push is accepted only if count < DEPTH, or if a pop happens in the same cycle.
  - At most one push per cycle. Non-winning senders stay blocked, because they receive no recv.
- Pop: if send is high and |done, the top entry is popped. Simultaneous done on several ports produces exactly one pop. done is ignored while send is 0.
- Offer: send = 4'b1111 when count > 0, except during the gap cycle. outData = top entry.
- Gap cycle: the cycle immediately after a pop forces send = 0. This covers the one-cycle done latency, so a second consumer cannot take a value that is already committed to leave.
- Same-cycle push + pop: the old top is removed and the pushed value becomes the new top. count is unchanged. The gap cycle still applies.
- Full (count == DEPTH) with no pop: no push is accepted, recv stays 0, and senders block indefinitely.
- Empty: send = 0, outData holds its last value, and done is ignored.
- Program-level rule: one neighbour must not read this node in two consecutive cycles. The gap cycle enforces this rule for any read that follows a completed pop.

## Timing
- Reset (rst high at a clk edge):
  - count = 0, send = 0, recv = 0, outData = 0, gap flag = 0.
  - Stored contents are discarded.
  - A reset mid-handshake drops any in-flight push or pop without a strobe.
- Push latency:
  - ready[k] is sampled in cycle N.
  - Write and count+1 occur at the end of N.
  - recv[k] = 1 in cycle N+1 only.
  - outData/send show the new top in N+1, unless N+1 is a gap cycle.
- Pop latency:
  - done seen in cycle M.
  - count-1 at the end of M.
  - send = 0 in M+1, with outData already showing the new top.
  - send reasserts in M+2 if count > 0.
- Back-to-back pushes from different ports: one per cycle, in priority order.
- Back-to-back pushes from the same port: at best every 2 cycles (the recv mask blocks the intervening cycle).
- Maximum pop rate: one pop every 2 cycles.
- recv and send are never combinational from inputs. All outputs are flops.

## Test plan
- Reset then idle: count = 0, send = 0, recv = 0, outData = 0. done pulses on all ports cause no change.
- Push 5 from port 2 (ready[2] held until recv[2]):
  - recv = 4'b0100 for exactly one cycle.
  - count = 1, outData = 5, send = 4'b1111 from the next cycle.
  - No second push while ready[2] is held during the recv cycle.
- Simultaneous ready on ports 1 and 3 with values 7 and -3:
  - Port 1 pushes first, port 3 one cycle later.
  - Final outData = -3, count = 2.
- Push 1, 2, 3, then pulse done[0]:
  - count drops 3 → 2.
  - send = 0 for one cycle, then outData = 2 with send = 4'b1111.
  - done on ports 0 and 2 in the same cycle pops only once.
- Fill to DEPTH = 15 with values 0..14, then hold ready[0] with value 99:
  - No recv, count stays 15.
  - Pulse done: the same cycle's push of 99 completes, count = 15, top = 99.
- Mid-operation reset with count = 4 and ready[1] asserted: next cycle count = 0, recv = 0, send = 0.
